// File: rtl/space_invaders_pkg.sv
// Shared screen limits, pixel colour type and shot FSM state encoding
// for the space-invaders display blocks.
package space_invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int POS_W    = 11;

  typedef logic [11:0]      rgb_t;
  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    SHOT_IDLE     = 2'd0,
    SHOT_FLYING   = 2'd1,
    SHOT_COOLDOWN = 2'd2
  } shot_state_t;

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser for an asynchronous push button, followed by a
// rising-edge detector; level_o is the synchronised button level.
module button_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/player_shot_controller.sv
// Player shot: launch from the ship, climb the screen, retire at the top or on a hit.
// Optional macro SHOT_AUTOFIRE_EN: launch on held fire level instead of on press edge.
//
//   state         | meaning
//   SHOT_IDLE     | no shot, waiting for fire
//   SHOT_FLYING   | shot climbing, shot_active high
//   SHOT_COOLDOWN | shot retired, fire locked out
module player_shot_controller
  import space_invaders_pkg::*;
#(
  parameter int   SHOT_START_Y    = 440,
  parameter int   SHOT_TOP        = 16,
  parameter int   SHOT_VELOCITY   = 4,
  parameter int   MOVE_INTERVAL   = 200000,
  parameter int   COOLDOWN_CYCLES = 1000000,
  parameter int   SHOT_W          = 2,
  parameter int   SHOT_H          = 8,
  parameter rgb_t SHOT_COLOR      = 12'hFF0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause,
  input  logic        fire,
  input  logic [10:0] player_x,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic        shot_hit,
  output logic        shot_active,
  output logic [10:0] shot_x,
  output logic [10:0] shot_y,
  output logic        shot_on,
  output logic [11:0] shot_rgb,
  output logic [7:0]  hit_count
);

`ifdef SHOT_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif

  localparam int CNT_MAX = (MOVE_INTERVAL > COOLDOWN_CYCLES) ? MOVE_INTERVAL : COOLDOWN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MOVE_TC = CNT_W'(MOVE_INTERVAL);
  localparam logic [CNT_W-1:0] COOL_TC = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam pos_t START_Y  = POS_W'(SHOT_START_Y);
  localparam pos_t RETIRE_Y = POS_W'(SHOT_TOP + SHOT_VELOCITY);
  localparam pos_t STEP_Y   = POS_W'(SHOT_VELOCITY);
  localparam pos_t SPR_W    = POS_W'(SHOT_W);
  localparam pos_t SPR_H    = POS_W'(SHOT_H);

  logic fire_level, fire_rise, launch_req;

  button_edge_sync u_fire_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (fire),
    .level_o (fire_level),
    .rise_o  (fire_rise)
  );

  assign launch_req = AUTOFIRE ? fire_level : fire_rise;

  shot_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pos_t             x_q, x_d, y_q, y_d;
  logic [7:0]       hits_q, hits_d;
  logic             on_q, on_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SHOT_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= START_Y;
      hits_q  <= '0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hits_q  <= hits_d;
      on_q    <= on_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    hits_d  = hits_q;
    if (!pause) begin
      unique case (state_q)
        SHOT_IDLE: begin
          if (launch_req) begin
            state_d = SHOT_FLYING;
            x_d     = player_x;
            y_d     = START_Y;
            cnt_d   = '0;
          end
        end
        SHOT_FLYING: begin
          // A hit wins over a move landing in the same clock
          if (shot_hit) begin
            state_d = SHOT_COOLDOWN;
            cnt_d   = '0;
            if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
          end else if (cnt_q == MOVE_TC) begin
            cnt_d = '0;
            if (y_q < RETIRE_Y) state_d = SHOT_COOLDOWN;
            else                y_d     = y_q - STEP_Y;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOT_COOLDOWN: begin
          if (cnt_q == COOL_TC) begin
            state_d = SHOT_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = SHOT_IDLE;
      endcase
    end
    on_d = (state_q == SHOT_FLYING) &&
           (pixel_x >= x_q) && (pixel_x < x_q + SPR_W) &&
           (pixel_y >= y_q) && (pixel_y < y_q + SPR_H);
  end

  assign shot_active = (state_q == SHOT_FLYING);
  assign shot_x      = x_q;
  assign shot_y      = y_q;
  assign shot_on     = on_q;
  assign shot_rgb    = on_q ? SHOT_COLOR : 12'h000;
  assign hit_count   = hits_q;

endmodule

// File: tb/tb_player_shot_controller.sv
// Directed and randomized checks of player_shot_controller against flight arithmetic.
module tb_player_shot_controller;

  localparam int MOVE_I  = 3;
  localparam int COOL_C  = 5;
  localparam int START_Y = 440;
  localparam int VEL     = 4;

  logic        clk = 1'b0;
  logic        reset_n, pause, fire, shot_hit;
  logic [10:0] player_x, pixel_x, pixel_y;
  logic        shot_active, shot_on;
  logic [10:0] shot_x, shot_y;
  logic [11:0] shot_rgb;
  logic [7:0]  hit_count;

  int total = 0;
  int bad   = 0;
  int hits  = 0;

  always #5 clk = ~clk;

  player_shot_controller #(
    .MOVE_INTERVAL   (MOVE_I),
    .COOLDOWN_CYCLES (COOL_C)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pause       (pause),
    .fire        (fire),
    .player_x    (player_x),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .shot_hit    (shot_hit),
    .shot_active (shot_active),
    .shot_x      (shot_x),
    .shot_y      (shot_y),
    .shot_on     (shot_on),
    .shot_rgb    (shot_rgb),
    .hit_count   (hit_count)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row of a shot k clocks after it entered flight: one move per MOVE_I+1 clocks
  function automatic int y_after(input int k);
    return START_Y - VEL * (k / (MOVE_I + 1));
  endfunction

  function automatic int sat255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  initial begin
    reset_n = 1'b1; pause = 1'b0; fire = 1'b0; shot_hit = 1'b0;
    player_x = '0; pixel_x = '0; pixel_y = '0;
    #1 reset_n = 1'b0;
    tick(2);
    chk("rst_active", shot_active, 0);
    chk("rst_x", shot_x, 0);
    chk("rst_y", shot_y, START_Y);
    chk("rst_hits", hit_count, 0);
    chk("rst_on", shot_on, 0);
    chk("rst_rgb", shot_rgb, 0);
    reset_n = 1'b1;
    tick(2);

    // launch at x=320, then sprite window boundaries
    player_x = 11'd320; fire = 1'b1;
    tick(3);
    chk("launch_active", shot_active, 1);
    chk("launch_x", shot_x, 320);
    chk("launch_y", shot_y, 440);
    fire = 1'b0; player_x = 11'd100; pixel_x = 11'd320; pixel_y = 11'd447;
    tick(1);
    chk("pix_in_on", shot_on, 1);
    chk("pix_in_rgb", shot_rgb, 12'hFF0);
    chk("x_const", shot_x, 320);
    pixel_x = 11'd322; pixel_y = 11'd440;
    tick(1);
    chk("pix_right_on", shot_on, 0);
    chk("pix_right_rgb", shot_rgb, 0);
    pixel_x = 11'd321; pixel_y = 11'd448;
    tick(1);
    chk("pix_below_on", shot_on, 0);
    chk("y_k3", shot_y, y_after(3));
    pixel_x = '0; pixel_y = '0;
    tick(1);
    chk("y_k4", shot_y, 436);

    // pause mid-flight with fire pressed during the pause
    pause = 1'b1; fire = 1'b1;
    tick(20);
    chk("pause_y", shot_y, 436);
    chk("pause_active", shot_active, 1);
    pause = 1'b0;
    tick(3);
    chk("unpause_y_k7", shot_y, y_after(7));
    fire = 1'b0;
    tick(1);
    chk("unpause_move_k8", shot_y, y_after(8));

    // free flight to the top
    tick(419);
    chk("top_active", shot_active, 1);
    chk("top_y", shot_y, 16);
    tick(1);
    chk("retire_active", shot_active, 0);
    chk("retire_y", shot_y, 16);
    shot_hit = 1'b1; pixel_x = 11'd320; pixel_y = 11'd16;
    tick(1);
    shot_hit = 1'b0; pixel_x = '0; pixel_y = '0;
    chk("cool_hit_count", hit_count, 0);
    chk("idle_pix_on", shot_on, 0);
    tick(1);
    fire = 1'b1;
    tick(3);
    chk("cool_last_fire_ignored", shot_active, 0);
    tick(1);
    chk("cool_fire_no_launch", shot_active, 0);
    fire = 1'b0;
    tick(4);
    shot_hit = 1'b1;
    tick(1);
    shot_hit = 1'b0;
    chk("idle_hit_count", hit_count, 0);
    chk("idle_hit_active", shot_active, 0);
    tick(2);

    // hit at row 200, then relaunch on the first idle clock
    player_x = 11'd77; fire = 1'b1;
    tick(3);
    fire = 1'b0;
    chk("launch2_x", shot_x, 77);
    tick(241);
    chk("hit_pre_y", shot_y, 200);
    shot_hit = 1'b1;
    tick(1);
    shot_hit = 1'b0; hits = 1;
    chk("hit_active", shot_active, 0);
    chk("hit_count1", hit_count, 1);
    chk("hit_y_held", shot_y, 200);
    tick(3);
    fire = 1'b1;
    tick(2);
    chk("cool_end_active", shot_active, 0);
    tick(1);
    chk("relaunch_active", shot_active, 1);
    chk("relaunch_y", shot_y, 440);
    fire = 1'b0;
    tick(2);
    shot_hit = 1'b1;
    tick(1);
    shot_hit = 1'b0; hits = 2;
    chk("hit_count2", hit_count, 2);
    tick(8);

    // fire pressed while paused in idle, held across unpause
    pause = 1'b1;
    tick(2);
    fire = 1'b1;
    tick(10);
    pause = 1'b0;
    tick(10);
    chk("pause_fire_no_shot", shot_active, 0);
    chk("pause_hits", hit_count, 2);
    fire = 1'b0;
    tick(4);

    // asynchronous reset mid-flight
    player_x = 11'd500; fire = 1'b1;
    tick(3);
    fire = 1'b0;
    chk("launch3_active", shot_active, 1);
    tick(9);
    pixel_x = 11'd500; pixel_y = 11'd432;
    tick(1);
    chk("pre_rst_on", shot_on, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_active", shot_active, 0);
    chk("arst_x", shot_x, 0);
    chk("arst_y", shot_y, START_Y);
    chk("arst_hits", hit_count, 0);
    chk("arst_on", shot_on, 0);
    chk("arst_rgb", shot_rgb, 0);
    @(negedge clk);
    reset_n = 1'b1; pixel_x = '0; pixel_y = '0; hits = 0;
    fire = 1'b1;
    tick(3);
    fire = 1'b0;
    chk("post_rst_launch", shot_active, 1);
    tick(5);
    shot_hit = 1'b1;
    tick(1);
    shot_hit = 1'b0; hits = 1;
    chk("post_rst_hits", hit_count, 1);
    tick(6);

    // random launches, flight lengths and hits; runs past hit_count saturation
    for (int i = 0; i < 258; i++) begin
      int          k;
      logic [10:0] px;
      px = 11'($urandom_range(0, 639));
      player_x = px; fire = 1'b1;
      tick(3);
      fire = 1'b0;
      player_x = 11'($urandom_range(0, 639));
      k = $urandom_range(0, 40);
      tick(k);
      chk("rnd_active", shot_active, 1);
      chk("rnd_x", shot_x, px);
      chk("rnd_y", shot_y, y_after(k));
      shot_hit = 1'b1;
      tick(1);
      shot_hit = 1'b0; hits++;
      chk("rnd_retired", shot_active, 0);
      chk("rnd_hits", hit_count, sat255(hits));
      tick(6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_shot_controller.md
PLAYER_SHOT_CONTROLLER -- requirements
Module: player_shot_controller

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- SHOT_START_Y, 440: launch row.
- SHOT_TOP, 16: retire row.
- SHOT_VELOCITY, 4: pixels per move.
- MOVE_INTERVAL, 200000: clocks per move.
- COOLDOWN_CYCLES, 1000000: post-shot lockout.
- SHOT_W, 2: sprite width.
- SHOT_H, 8: sprite height.
- SHOT_COLOR, 12'hFF0: shot colour.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk in 1: system clock.
- reset_n in 1: async active-low reset.
- pause in 1: freeze.
- fire in 1: raw fire button, asynchronous.
- player_x in 11: ship centre x.
- pixel_x, pixel_y in 11 each: VGA scan position.
- shot_hit in 1: hit pulse from the alien block.
- shot_active out 1: shot in flight.
- shot_x, shot_y out 11 each: shot position.
- shot_on out 1: shot pixel visible.
- shot_rgb out 12: shot pixel colour.
- hit_count out 8: aliens destroyed.

Function
REQ-004 SHALL synchronise fire through two flops, then rising-edge detect it (fire_rise).
REQ-005 SHALL implement FSM IDLE, FLYING, COOLDOWN; shot_active SHALL equal (state==FLYING).
REQ-006 IDLE: on fire_rise, SHALL latch shot_x<=player_x and shot_y<=SHOT_START_Y, clear move counter, and enter FLYING on the next clock.
REQ-007 FLYING: move counter SHALL count 0..MOVE_INTERVAL; at terminal count, if shot_y < SHOT_TOP+SHOT_VELOCITY then enter COOLDOWN, else shot_y -= SHOT_VELOCITY.
REQ-008 FLYING: shot_hit SHALL take priority over move, enter COOLDOWN the same clock, and increment hit_count, saturating at 255.
REQ-009 shot_hit SHALL be ignored in IDLE and COOLDOWN.
REQ-010 COOLDOWN: SHALL count COOLDOWN_CYCLES clocks, then enter IDLE; fire_rise SHALL be ignored during this state.
REQ-011 pause=1 SHALL freeze state, counters, shot_x/shot_y and hit_count.
REQ-012 The synchroniser SHALL keep running during pause, so a button held across unpause yields no fire_rise.
REQ-013 shot_x SHALL be constant while in FLYING; player_x changes SHALL not affect a launched shot.
REQ-014 shot_on SHALL be registered (1-clock latency) and high iff shot_active, shot_x<=pixel_x<shot_x+SHOT_W, and shot_y<=pixel_y<shot_y+SHOT_H.
REQ-015 shot_rgb SHALL be SHOT_COLOR when shot_on is high, else 12'h000.
REQ-016 All position arithmetic SHALL be 11-bit unsigned; the retire comparison SHALL precede subtraction, so shot_y never wraps.

Reset
REQ-017 reset_n=0 SHALL asynchronously force:
- state=IDLE, shot_active=0
- shot_x=0, shot_y=SHOT_START_Y
- counters=0, hit_count=0
- shot_on=0, shot_rgb=12'h000
- synchroniser flops=0
REQ-018 Reset mid-flight SHALL kill the shot immediately, with no COOLDOWN entry.

Configuration
REQ-019 Macro SHOT_AUTOFIRE_EN: when defined, IDLE SHALL launch whenever synchronised fire is high (level); when undefined, launch SHALL require fire_rise only.

Structure
REQ-020 Shared package space_invaders_pkg SHALL hold screen limits, the 12-bit rgb typedef, and the shot FSM state enum.
REQ-021 The synchroniser and edge detector SHALL be sub-module button_edge_sync; all other logic stays inline.

Verification
REQ-022 The bench SHALL cover these scenarios (MOVE_INTERVAL=3, COOLDOWN_CYCLES=5 for the bench):
- Fire pulse with player_x=320 -> shot_active=1, shot_x=320, shot_y=440; shot_y=436 after 4 clocks.
- Free flight to the top -> at shot_y=16 (<20) COOLDOWN entered; shot_active=0; IDLE 5 clocks later.
- shot_hit at shot_y=200 -> shot_active=0 next clock; hit_count 0->1; 256 hits -> hit_count=255.
- Fire during COOLDOWN, and shot_hit in IDLE -> no launch, hit_count unchanged.
- pause=1 for 20 clocks mid-flight -> shot_y unchanged; fire held across unpause -> no new shot.
- reset_n low mid-flight -> all outputs at reset values asynchronously; pixel at (shot_x, shot_y+7) -> shot_on=1 and shot_rgb=12'hFF0 one clock later; (shot_x+2, shot_y) -> shot_on=0.
